apb_uart_req_arbiter: RTL and testbench
=======================================

// Module: apb_uart_req_arbiter
// PURPOSE
//  Two-requester APB master that shares one apb_uart_top slave port (e.g. host CPU on port 0, DMA/test sequencer on port 1).
//  Round-robin arbitration, one outstanding transfer total, APB SETUP/ACCESS sequencing with wait states, PSLVERR forwarding
//  and a PREADY timeout. Sits directly in front of apb_uart_top; its APB outputs drive that block's APB inputs 1:1.
// PARAMETERS
//  DATA_WIDTH      32  width of PWDATA/PRDATA and requester data
//  ADDR_WIDTH      32  width of PADDR and requester address
//  TIMEOUT_CYCLES  16  max ACCESS cycles waiting for PREADY; 0 = timeout disabled
// PORTS
//  PCLK        in   1           clock, all logic rising-edge
//  PRESETn     in   1           asynchronous active-low reset
//  req0_valid  in   1           port 0 transfer request; hold with fields stable until req0_ready
//  req0_write  in   1           1 = write, 0 = read
//  req0_addr   in   ADDR_WIDTH  target register address
//  req0_wdata  in   DATA_WIDTH  write data
//  req0_ready  out  1           accept strobe; fields captured this cycle
//  req0_rvalid out  1           one-cycle completion pulse
//  req0_rdata  out  DATA_WIDTH  read data, valid with req0_rvalid (0 for writes/errors)
//  req0_err    out  1           PSLVERR or timeout, valid with req0_rvalid
//  req1_*      --   --          identical set for port 1
//  PSELx       out  1           APB select
//  PENABLE     out  1           APB enable
//  PWRITE      out  1           APB direction
//  PADDR       out  ADDR_WIDTH  APB address
//  PWDATA      out  DATA_WIDTH  APB write data
//  PRDATA      in   DATA_WIDTH  APB read data
//  PREADY      in   1           APB ready
//  PSLVERR     in   1           APB slave error
// BEHAVIOUR
//  - Reset (PRESETn=0, immediate): state IDLE; all outputs 0; rr pointer favours port 0; timeout counter 0; in-flight transfer dropped, no rvalid.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE. Registered APB outputs; reqN_ready combinational from state+valids.
//  - IDLE: if any valid, grant; granted reqN_ready=1 one cycle; addr/wdata/write/owner latched; -> SETUP. Else stay.
//  - Arbitration: only one valid -> grant it. Both valid -> grant port != last granted (after reset: port 0). Pointer updates on grant only.
//  - SETUP (1 cycle): PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA from latch; -> ACCESS.
//  - ACCESS: PSELx=1, PENABLE=1, signals stable; counter increments each cycle PREADY=0.
//  - PREADY=1 sampled in ACCESS: next cycle owner rvalid=1, rdata=PRDATA (reads; 0 for writes), err=PSLVERR; PSELx/PENABLE=0; -> IDLE.
//  - Timeout: TIMEOUT_CYCLES consecutive ACCESS cycles with PREADY=0 -> terminate: PSELx/PENABLE=0, owner rvalid=1, err=1, rdata=0; -> IDLE.
//    PREADY rising on the same edge as expiry counts as normal completion.
//  - Latency (no wait states): ready at T, SETUP T+1, ACCESS T+2, rvalid T+3; next grant earliest T+3 (IDLE coincides with rvalid).
//  - Non-owner never sees ready/rvalid; a valid dropped before ready is simply not granted (no latching).
//  - Counter width $clog2(TIMEOUT_CYCLES+1), saturating; cleared on entering SETUP.
//  - PWDATA driven 0 for reads; PADDR/PWRITE hold last value while idle.
// TESTING
//  1. req0 write addr 0x4 data 0xA5, PREADY=1 -> ready@T, PSELx@T+1, PENABLE@T+2, req0_rvalid@T+3 err=0.
//  2. req0,req1 valid together after reset -> port 0 first, port 1 on next IDLE; repeat both-valid -> 0,1,0,1 alternation.
//  3. req1 read addr 0x8, PREADY low 3 ACCESS cycles, PRDATA=0x3C -> signals stable throughout, rvalid 4 cycles after ACCESS entry, rdata=0x3C.
//  4. PSLVERR=1 with PREADY=1 on req0 read -> req0_rvalid=1, req0_err=1, rdata=0.
//  5. TIMEOUT_CYCLES=16, PREADY never high -> PSELx drops after 16 ACCESS cycles, rvalid err=1; TIMEOUT_CYCLES=0 -> waits indefinitely.
//  6. PRESETn low mid-ACCESS -> all outputs 0 at once, no rvalid; after release both-valid grants port 0.

Source files
------------

// File: rtl/apb_uart_req_arbiter.sv
// ============================================================================
// apb_uart_req_arbiter : two-port round-robin APB master for apb_uart_top
// Revision: 1.0
// ============================================================================
`default_nettype none

module apb_uart_req_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_limit   = c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [c_cnt_w-1:0] c_cnt_max = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_expire;
  logic                  r_last;
  logic                  r_owner;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [1:0]            r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // On contention the port that was not granted last wins; r_last resets to 1 so port 0 leads.
  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      IDLE: begin
        w_grant0 = req0_valid && (!req1_valid || r_last);
        w_grant1 = req1_valid && (!req0_valid || !r_last);
        if (w_grant0 || w_grant1) w_state_nxt = SETUP;
      end
      SETUP: w_state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          w_state_nxt = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == c_limit)) begin
          w_expire    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSELx    <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_cnt    <= '0;
      r_rvalid <= 2'b00;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= 2'b00;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant0 || w_grant1) begin
            r_owner <= w_grant1;
            r_last  <= w_grant1;
            PSELx   <= 1'b1;
            PENABLE <= 1'b0;
            PADDR   <= w_grant1 ? req1_addr : req0_addr;
            PWRITE  <= w_grant1 ? req1_write : req0_write;
            if (w_grant1) PWDATA <= req1_write ? req1_wdata : '0;
            else          PWDATA <= req0_write ? req0_wdata : '0;
            r_cnt   <= '0;
          end
        end
        SETUP: PENABLE <= 1'b1;
        ACCESS: begin
          if (PREADY) begin
            PSELx             <= 1'b0;
            PENABLE           <= 1'b0;
            r_rvalid[r_owner] <= 1'b1;
            r_rdata           <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            r_err             <= PSLVERR;
          end else if (w_expire) begin
            PSELx             <= 1'b0;
            PENABLE           <= 1'b0;
            r_rvalid[r_owner] <= 1'b1;
            r_err             <= 1'b1;
          end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign req0_rvalid = r_rvalid[0];
  assign req1_rvalid = r_rvalid[1];
  assign req0_rdata  = r_rvalid[0] ? r_rdata : '0;
  assign req1_rdata  = r_rvalid[1] ? r_rdata : '0;
  assign req0_err    = r_rvalid[0] & r_err;
  assign req1_err    = r_rvalid[1] & r_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_uart_req_arbiter.sv
// ============================================================================
// tb_apb_uart_req_arbiter : directed stimulus with queued response scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_uart_req_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0, req1_valid = 1'b0, req1_write = 1'b0;
  logic [31:0] req0_addr = '0, req0_wdata = '0, req1_addr = '0, req1_wdata = '0;
  logic        req0_ready, req0_rvalid, req0_err, req1_ready, req1_rvalid, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic        PSELx, PENABLE, PWRITE, PREADY;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] resp_data = '0;
  logic        resp_err = 1'b0;
  logic        hang = 1'b0;
  int          wait_n = 0;
  logic [7:0]  acc_cnt = '0;

  // Second instance with the timeout disabled
  logic        z_valid = 1'b0, z_pready = 1'b0;
  logic        z_ready, z_rvalid, z_err, z_ready1, z_rvalid1, z_err1;
  logic [31:0] z_rdata, z_rdata1, z_paddr, z_pwdata;
  logic        z_psel, z_penable, z_pwrite;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct { int port; logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } apb_t;
  rsp_t sbq[$];
  apb_t apbq[$];
  int   grant_log[$];
  rsp_t e;

  always #5 PCLK = ~PCLK;

  assign PREADY = PSELx && PENABLE && !hang && (int'(acc_cnt) >= wait_n);
  always @(posedge PCLK) acc_cnt <= (PSELx && PENABLE && !PREADY) ? acc_cnt + 8'd1 : 8'd0;

  apb_uart_req_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(resp_data), .PREADY(PREADY), .PSLVERR(resp_err)
  );

  apb_uart_req_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nto (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(z_valid), .req0_write(1'b1), .req0_addr(32'h10), .req0_wdata(32'h77),
    .req0_ready(z_ready), .req0_rvalid(z_rvalid), .req0_rdata(z_rdata), .req0_err(z_err),
    .req1_valid(1'b0), .req1_write(1'b0), .req1_addr(32'h0), .req1_wdata(32'h0),
    .req1_ready(z_ready1), .req1_rvalid(z_rvalid1), .req1_rdata(z_rdata1), .req1_err(z_err1),
    .PSELx(z_psel), .PENABLE(z_penable), .PWRITE(z_pwrite), .PADDR(z_paddr), .PWDATA(z_pwdata),
    .PRDATA(32'h0), .PREADY(z_pready), .PSLVERR(1'b0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_err++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Raise a request, wait (bounded) for ready, queue the expected APB phase and response.
  task automatic issue(input int port, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata_exp, input bit err_exp);
    bit got = 1'b0;
    if (port == 0) begin req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wdata; end
    else           begin req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wdata; end
    for (int i = 0; i < 200; i++) begin
      @(negedge PCLK);
      if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin got = 1'b1; break; end
    end
    if (got) begin
      sbq.push_back('{port, rdata_exp, err_exp});
      apbq.push_back('{addr, wr, wr ? wdata : 32'h0});
      grant_log.push_back(port);
    end else begin
      fail_now("ready_timeout", $sformatf("port %0d got no ready, required within 200 cycles", port));
    end
    @(posedge PCLK); #1;
    if (port == 0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  task automatic wait_penable(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (PENABLE) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("penable_timeout", "got no PENABLE, required within 100 cycles");
  endtask

  // Response and APB-phase monitor
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (req0_ready && req1_ready) fail_now("ready_exclusive", "got both readies, required one");
      if (req0_rvalid || req1_rvalid) begin
        check("rvalid_exclusive", 64'(req0_rvalid & req1_rvalid), 64'd0);
        if (sbq.size() == 0) begin
          fail_now("rsp_unexpected", "got rvalid, required none");
        end else begin
          e = sbq.pop_front();
          check("rsp_port",  64'(req1_rvalid ? 1 : 0), 64'(e.port));
          check("rsp_rdata", 64'(req1_rvalid ? req1_rdata : req0_rdata), 64'(e.rdata));
          check("rsp_err",   64'(req1_rvalid ? req1_err : req0_err), 64'(e.err));
        end
        if (apbq.size() > 0) void'(apbq.pop_front());
      end
      if (PSELx) begin
        if (apbq.size() == 0) fail_now("apb_unexpected", "got PSELx, required idle");
        else begin
          check("apb_paddr",  64'(PADDR),  64'(apbq[0].addr));
          check("apb_pwrite", 64'(PWRITE), 64'(apbq[0].wr));
          check("apb_pwdata", 64'(PWDATA), 64'(apbq[0].wdata));
        end
      end
    end
  end

  initial begin
    bit ok;
    int n;

    // Reset state
    #1;
    check("rst_psel",    64'(PSELx),   64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_paddr",   64'(PADDR),   64'd0);
    check("rst_ready",   64'({req0_ready, req1_ready, req0_rvalid, req1_rvalid}), 64'd0);
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // Contended requests alternate 0,1,0,1 starting at port 0
    resp_data = 32'h1122_3344;
    @(posedge PCLK); #1;
    fork
      begin issue(0, 1'b1, 32'h10, 32'h1, 32'h0, 1'b0); issue(0, 1'b0, 32'h14, 32'h2, 32'h1122_3344, 1'b0); end
      begin issue(1, 1'b1, 32'h20, 32'h3, 32'h0, 1'b0); issue(1, 1'b0, 32'h24, 32'h4, 32'h1122_3344, 1'b0); end
    join
    check("rr_count", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4) begin
      check("rr_g0", 64'(grant_log[0]), 64'd0);
      check("rr_g1", 64'(grant_log[1]), 64'd1);
      check("rr_g2", 64'(grant_log[2]), 64'd0);
      check("rr_g3", 64'(grant_log[3]), 64'd1);
    end
    repeat (4) @(posedge PCLK); #1;

    // Zero-wait write latency: ready T, SETUP T+1, ACCESS T+2, rvalid T+3
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h4; req0_wdata = 32'hA5;
    @(negedge PCLK);
    check("lat_ready", 64'(req0_ready), 64'd1);
    sbq.push_back('{0, 32'h0, 1'b0});
    apbq.push_back('{32'h4, 1'b1, 32'hA5});
    @(posedge PCLK); #1 req0_valid = 1'b0;
    @(negedge PCLK);
    check("lat_setup", 64'({PSELx, PENABLE}), 64'b10);
    @(negedge PCLK);
    check("lat_access", 64'({PSELx, PENABLE}), 64'b11);
    @(negedge PCLK);
    check("lat_rvalid", 64'(req0_rvalid), 64'd1);
    repeat (2) @(posedge PCLK); #1;

    // Three wait states on a port 1 read
    wait_n = 3; resp_data = 32'h3C;
    fork
      issue(1, 1'b0, 32'h8, 32'hFFFF, 32'h3C, 1'b0);
      begin
        wait_penable(ok);
        n = 0;
        if (ok) begin
          for (int i = 0; i < 50; i++) begin
            @(negedge PCLK);
            n++;
            if (req1_rvalid) break;
          end
          check("wait_latency", 64'(n), 64'd4);
        end
      end
    join
    wait_n = 0;
    repeat (3) @(posedge PCLK); #1;

    // Slave error on a read
    resp_err = 1'b1; resp_data = 32'h55;
    issue(0, 1'b0, 32'hC, 32'h9, 32'h0, 1'b1);
    repeat (3) @(posedge PCLK); #1;
    resp_err = 1'b0;

    // PREADY never arrives: terminate after 16 ACCESS cycles
    hang = 1'b1;
    fork
      issue(1, 1'b0, 32'h18, 32'h0, 32'h0, 1'b1);
      begin
        wait_penable(ok);
        if (ok) begin
          n = 1;
          for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (!PSELx) break;
            n++;
          end
          check("timeout_cycles", 64'(n), 64'd16);
          check("timeout_rvalid", 64'(req1_rvalid), 64'd1);
        end
      end
    join
    repeat (3) @(posedge PCLK); #1;

    // Reset mid-ACCESS with port 0 as last grantee
    issue(0, 1'b1, 32'h1C, 32'hDEAD, 32'h0, 1'b0);
    wait_penable(ok);
    repeat (3) @(posedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    check("mid_rst_apb", 64'({PSELx, PENABLE, PWRITE}), 64'd0);
    check("mid_rst_addr", 64'({PADDR, PWDATA}), 64'd0);
    check("mid_rst_rsp", 64'({req0_rvalid, req1_rvalid}), 64'd0);
    sbq.delete();
    apbq.delete();
    hang = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    grant_log.delete();
    @(posedge PCLK); #1;
    fork
      issue(0, 1'b1, 32'h30, 32'h5, 32'h0, 1'b0);
      issue(1, 1'b1, 32'h34, 32'h6, 32'h0, 1'b0);
    join
    check("post_rst_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) check("post_rst_first", 64'(grant_log[0]), 64'd0);
    repeat (5) @(posedge PCLK); #1;
    check("sb_drained", 64'(sbq.size()), 64'd0);

    // Timeout disabled: ACCESS persists until PREADY
    z_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (z_ready) begin ok = 1'b1; break; end
    end
    check("nto_ready", 64'(ok), 64'd1);
    @(posedge PCLK); #1 z_valid = 1'b0;
    repeat (40) @(negedge PCLK);
    check("nto_still_access", 64'({z_psel, z_penable, z_rvalid}), 64'b110);
    @(posedge PCLK); #1 z_pready = 1'b1;
    @(posedge PCLK); #1 z_pready = 1'b0;
    @(negedge PCLK);
    check("nto_done", 64'({z_rvalid, z_err, z_psel}), 64'b100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required finish");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
